ss_multiplier: RTL and testbench

SS_MULTIPLIER -- requirements
Module: ss_multiplier

---
 rtl/ss_multiplier_if.sv | 22 ++
 rtl/ss_multiplier.sv | 96 +++++++++
 tb/tb_ss_multiplier.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ss_multiplier_if.sv
// Handshake/data bundle for the shift-add multiplier: start request and
// operands in, registered product with busy/valid status out.
interface ss_multiplier_if #(
    parameter int SIZE_DATA = 32
);
    logic                   i_en_multiply;
    logic [SIZE_DATA-1:0]   i_multiplicand;
    logic [SIZE_DATA-1:0]   i_multiplier;
    logic [2*SIZE_DATA-1:0] o_product;
    logic                   o_busy;
    logic                   o_valid;

    modport master (
        output i_en_multiply, i_multiplicand, i_multiplier,
        input  o_product, o_busy, o_valid
    );

    modport slave (
        input  i_en_multiply, i_multiplicand, i_multiplier,
        output o_product, o_busy, o_valid
    );
endinterface

// File: rtl/ss_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one partial product per cycle,
// SIZE_DATA CALC cycles per operation, zero operands short-circuit to DONE.
module ss_multiplier #(
    parameter int SIZE_DATA = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ss_multiplier_if.slave  mul
);
    localparam int W2 = 2 * SIZE_DATA;
    localparam logic [SIZE_DATA-1:0] CNT_INIT = SIZE_DATA'(SIZE_DATA);
    localparam logic [SIZE_DATA-1:0] CNT_ONE  = SIZE_DATA'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [W2-1:0]        acc;
    logic [W2-1:0]        mcand;
    logic [SIZE_DATA-1:0] mplier;
    logic [SIZE_DATA-1:0] cnt;
    logic [W2-1:0]        product_q;
    logic                 busy_q;
    logic                 valid_q;
    logic [W2-1:0]        acc_sum;
    logic                 zero_op;

    // The accumulator is as wide as the product, so the sum cannot overflow.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;
    assign zero_op = (mul.i_multiplicand == '0) || (mul.i_multiplier == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (mul.i_en_multiply) begin
                        acc    <= '0;
                        busy_q <= 1'b1;
                        if (zero_op) begin
                            mcand     <= '0;
                            mplier    <= '0;
                            cnt       <= '0;
                            product_q <= '0;
                            valid_q   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mcand  <= W2'(mul.i_multiplicand);
                            mplier <= mul.i_multiplier;
                            cnt    <= CNT_INIT;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_ONE;
                    // Last step: publish the sum including this cycle's partial product.
                    if (cnt == CNT_ONE) begin
                        product_q <= acc_sum;
                        valid_q   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign mul.o_product = product_q;
    assign mul.o_busy    = busy_q;
    assign mul.o_valid   = valid_q;
endmodule

// File: tb/tb_ss_multiplier.sv
// Directed self-checking bench for ss_multiplier with SIZE_DATA=32.
module tb_ss_multiplier;
    localparam int N = 32;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n, bcnt, chg, pulses;

    always #5 i_clk = ~i_clk;

    ss_multiplier_if #(.SIZE_DATA(N)) mif ();

    ss_multiplier #(.SIZE_DATA(N)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .mul   (mif)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for o_valid; counts edges, busy samples and product changes before it.
    task automatic wait_valid(output int edges, output int busy_n, output int changes);
        logic [2*N-1:0] prev;
        prev    = mif.o_product;
        edges   = 0;
        busy_n  = 0;
        changes = 0;
        while (!mif.o_valid && edges < 200) begin
            tick();
            edges++;
            if (mif.o_busy) busy_n++;
            if (!mif.o_valid && mif.o_product !== prev) changes++;
        end
    endtask

    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b);
        mif.i_multiplicand = a;
        mif.i_multiplier   = b;
        mif.i_en_multiply  = 1'b1;
        tick();
        mif.i_en_multiply  = 1'b0;
    endtask

    initial begin
        mif.i_en_multiply  = 1'b0;
        mif.i_multiplicand = '0;
        mif.i_multiplier   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_product", mif.o_product, 0);
        chk("rst_valid", mif.o_valid, 0);
        chk("rst_busy", mif.o_busy, 0);
        i_rst = 1'b0;

        // 7 * 6
        start(7, 6);
        chk("basic_busy_after_accept", mif.o_busy, 1);
        wait_valid(n, bcnt, chg);
        chk("basic_latency", n, N);
        chk("basic_product", mif.o_product, 42);
        chk("basic_busy_cycles", bcnt + 1, N + 1);
        chk("basic_product_stable", chg, 0);
        tick();
        chk("basic_valid_one_cycle", mif.o_valid, 0);
        chk("basic_busy_drop", mif.o_busy, 0);

        // Maximum operands
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(n, bcnt, chg);
        chk("max_latency", n, N);
        chk("max_product", mif.o_product, 64'hFFFF_FFFE_0000_0001);
        chk("max_product_stable", chg, 0);
        tick();

        // Zero operand short path
        start(0, 32'h1234_5678);
        chk("zero_valid", mif.o_valid, 1);
        chk("zero_product", mif.o_product, 0);
        chk("zero_busy", mif.o_busy, 1);
        tick();
        chk("zero_valid_drop", mif.o_valid, 0);
        chk("zero_busy_drop", mif.o_busy, 0);

        // Start request mid-CALC must be ignored
        start(3, 5);
        repeat (5) tick();
        mif.i_multiplicand = 9;
        mif.i_multiplier   = 9;
        mif.i_en_multiply  = 1'b1;
        tick();
        mif.i_en_multiply  = 1'b0;
        wait_valid(n, bcnt, chg);
        chk("ignore_latency", n + 6, N);
        chk("ignore_product", mif.o_product, 15);
        pulses = 0;
        repeat (40) begin
            tick();
            if (mif.o_valid) pulses++;
        end
        chk("ignore_no_extra_valid", pulses, 0);

        // Reset mid-operation aborts without a valid pulse
        start(100, 200);
        pulses = 0;
        repeat (9) begin
            tick();
            if (mif.o_valid) pulses++;
        end
        i_rst = 1'b1;
        tick();
        chk("abort_product", mif.o_product, 0);
        chk("abort_busy", mif.o_busy, 0);
        chk("abort_valid", mif.o_valid, 0);
        i_rst = 1'b0;
        repeat (40) begin
            tick();
            if (mif.o_valid) pulses++;
        end
        chk("abort_no_valid", pulses, 0);
        start(2, 3);
        wait_valid(n, bcnt, chg);
        chk("after_abort_latency", n, N);
        chk("after_abort_product", mif.o_product, 6);
        tick();

        // Start present during a reset edge is deferred to the first free edge
        i_rst = 1'b1;
        mif.i_multiplicand = 4;
        mif.i_multiplier   = 5;
        mif.i_en_multiply  = 1'b1;
        tick();
        chk("start_in_reset_ignored", mif.o_busy, 0);
        i_rst = 1'b0;
        tick();
        mif.i_en_multiply = 1'b0;
        chk("start_after_reset_busy", mif.o_busy, 1);
        wait_valid(n, bcnt, chg);
        chk("start_after_reset_latency", n, N);
        chk("start_after_reset_product", mif.o_product, 20);
        tick();

        // Back-to-back with start held high
        mif.i_multiplicand = 32'h0001_0000;
        mif.i_multiplier   = 32'h0001_0000;
        mif.i_en_multiply  = 1'b1;
        tick();
        wait_valid(n, bcnt, chg);
        chk("b2b_first_latency", n, N);
        chk("b2b_first_product", mif.o_product, 64'h1_0000_0000);
        repeat (2) begin
            tick();
            wait_valid(n, bcnt, chg);
            chk("b2b_period", n + 1, N + 2);
            chk("b2b_product", mif.o_product, 64'h1_0000_0000);
        end
        mif.i_en_multiply = 1'b0;
        tick();
        tick();
        chk("b2b_stop_idle", mif.o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
